// File: rtl/crubits_sync.sv
// crubits_sync: CRU bit bank for the TIPI PEB card.
//
// The TI CRU bus signals are sampled into the clk domain. Writes to this
// card's CRU page (>1x00, x = cru_base) update a bank of NUM_BITS bits and
// pulse a one-cycle strobe for the bit written. CRU reads are answered
// combinationally from the raw bus. Bits flagged in INPUT_MASK are
// read-only and return ext_in.
//
// Ports:
//   clk           system clock
//   reset_n       synchronous, active-low reset
//   cru_base      card page select (page = >1000 + cru_base * >100)
//   ti_cru_clk    TI CRUCLK (async), active level set by CRUCLK_ACTIVE_HIGH
//   ti_memen      TI MEMEN (async); CRU cycles only while high
//   addr          TI A0..A14 (async), addr[0] = A0 = MSB
//   ti_cru_out    TI CRUOUT write data (async)
//   ext_in        status inputs for read-only bits (clk domain)
//   ti_cru_in     CRU read data (combinational)
//   ti_cru_in_oe  high while this card drives CRUIN
//   bits          registered bit state, bits[0] = CRU bit 0
//   bit_wr        one-clk strobe per bit written
module crubits_sync #(
  parameter int                  NUM_BITS           = 4,
  parameter logic [NUM_BITS-1:0] RESET_VALUE        = '0,
  parameter logic [NUM_BITS-1:0] INPUT_MASK         = '0,
  parameter bit                  CRUCLK_ACTIVE_HIGH = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [3:0]          cru_base,
  input  logic                ti_cru_clk,
  input  logic                ti_memen,
  input  logic [0:14]         addr,
  input  logic                ti_cru_out,
  input  logic [NUM_BITS-1:0] ext_in,
  output logic                ti_cru_in,
  output logic                ti_cru_in_oe,
  output logic [NUM_BITS-1:0] bits,
  output logic [NUM_BITS-1:0] bit_wr
);

  localparam logic IDLE_LVL = CRUCLK_ACTIVE_HIGH ? 1'b0 : 1'b1;

  logic        cruclk_p0, cruclk_p1, cruclk_p2;
  logic        memen_p0, memen_p1;
  logic [0:14] addr_p0, addr_p1;
  logic        cru_out_p0, cru_out_p1;

  logic        edge_act;
  logic        hit_s;
  logic [6:0]  idx_s;
  logic        wr_fire;

  logic        hit_r;
  logic [6:0]  idx_r;
  logic        sel_r;
  logic        rd_bit;

  // Stage p0/p1: two-flop synchronisers; p2: edge-detect history.
  // CRUCLK flops reset to the idle level so releasing reset cannot look
  // like an active edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cruclk_p0 <= IDLE_LVL;
      cruclk_p1 <= IDLE_LVL;
      cruclk_p2 <= IDLE_LVL;
      memen_p0  <= 1'b0;
      memen_p1  <= 1'b0;
    end else begin
      cruclk_p0 <= ti_cru_clk;
      cruclk_p1 <= cruclk_p0;
      cruclk_p2 <= cruclk_p1;
      memen_p0  <= ti_memen;
      memen_p1  <= memen_p0;
    end
  end

  always_ff @(posedge clk) begin
    addr_p0    <= addr;
    addr_p1    <= addr_p0;
    cru_out_p0 <= ti_cru_out;
    cru_out_p1 <= cru_out_p0;
  end

  assign edge_act = CRUCLK_ACTIVE_HIGH ? ( cruclk_p1 & ~cruclk_p2)
                                       : (~cruclk_p1 &  cruclk_p2);

  // cru_base is quasi-static and used directly without synchronisation.
  assign hit_s   = (addr_p1[0:3] == 4'b0001) && (addr_p1[4:7] == cru_base) && memen_p1;
  assign idx_s   = addr_p1[8:14];
  assign wr_fire = edge_act && hit_s;

  // Bit register stage: an edge coinciding with reset is dropped because
  // the reset branch takes priority. Masked bits never leave RESET_VALUE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bits   <= RESET_VALUE;
      bit_wr <= '0;
    end else begin
      bit_wr <= '0;
      if (wr_fire) begin
        for (int i = 0; i < NUM_BITS; i++) begin
          if (idx_s == 7'(i) && !INPUT_MASK[i]) begin
            bits[i]   <= cru_out_p1;
            bit_wr[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Read path: raw bus decode, no clock latency.
  assign hit_r = (addr[0:3] == 4'b0001) && (addr[4:7] == cru_base) && ti_memen;
  assign idx_r = addr[8:14];

  always_comb begin
    sel_r  = 1'b0;
    rd_bit = 1'b0;
    for (int i = 0; i < NUM_BITS; i++) begin
      if (hit_r && idx_r == 7'(i)) begin
        sel_r  = 1'b1;
        rd_bit = INPUT_MASK[i] ? ext_in[i] : bits[i];
      end
    end
  end

  assign ti_cru_in    = rd_bit;
  assign ti_cru_in_oe = sel_r && reset_n;

endmodule
